// File: rtl/reg_dump_streamer_pkg.sv
// Shared definitions for the register dump streamer: FSM encoding, default
// frame marker and the frame-length helper also used by the bench decoder.
package reg_dump_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_IDX    = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5
  } state_e;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Header + (index byte + data bytes) per register + checksum.
  function automatic int frame_len(input int num_regs, input int data_w);
    return 2 + num_regs * (1 + data_w / 8);
  endfunction

  localparam int FRAME_LEN_DEFAULT = frame_len(32, 32);

endpackage

// File: rtl/reg_dump_streamer_byte_shifter.sv
// Holds one sampled register word and presents it MSB byte first; flags the
// final byte of the word so the FSM knows when to move on.
module byte_shifter #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              shift_i,
  output logic [7:0]        byte_o,
  output logic [7:0]        next_byte_o,
  output logic              last_byte_o
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] sh_q, sh_d, shifted_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign shifted_s = sh_q << 8;

  // Load has priority over shift; counter tracks bytes already consumed.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d  = shifted_s;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign byte_o      = sh_q[DATA_W-1 -: 8];
  assign next_byte_o = shifted_s[DATA_W-1 -: 8];
  assign last_byte_o = (cnt_q == CNT_W'(NB - 1));

endmodule

// File: rtl/reg_dump_streamer.sv
// Streams the register file as a framed byte sequence (header, index+data per
// register, XOR checksum) over a valid/ready handshake with registered outputs.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter int         DATA_W   = 32,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT,
  parameter int         IDX_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs_s, load_s, shift_s;
  logic [7:0]       byte_s, next_byte_s;
  logic             last_byte_s;

  assign hs_s = tx_valid_q && tx_ready;

  byte_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load_s),
    .data_i      (data_readReg),
    .shift_i     (shift_s),
    .byte_o      (byte_s),
    .next_byte_o (next_byte_s),
    .last_byte_o (last_byte_s)
  );

  // Next-state logic; tx_* are computed one cycle ahead so they leave registers.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    if (hs_s && (state_q != ST_CSUM)) begin
      csum_d = csum_q ^ tx_data_q;
    end else begin
      csum_d = csum_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_HDR;
          idx_d      = '0;
          csum_d     = 8'h00;
          tx_data_d  = HDR_BYTE;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (hs_s) begin
          state_d    = ST_SAMPLE;
          tx_valid_d = 1'b0;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_SAMPLE: begin
        load_s     = 1'b1;
        state_d    = ST_IDX;
        tx_data_d  = 8'(idx_q);
        tx_valid_d = 1'b1;
      end
      ST_IDX: begin
        if (hs_s) begin
          state_d   = ST_DATA;
          tx_data_d = byte_s;
        end else begin
          state_d = ST_IDX;
        end
      end
      ST_DATA: begin
        if (hs_s) begin
          shift_s = 1'b1;
          if (!last_byte_s) begin
            tx_data_d = next_byte_s;
          end else if (idx_q != IDX_W'(NUM_REGS - 1)) begin
            state_d    = ST_SAMPLE;
            idx_d      = idx_q + IDX_W'(1);
            tx_valid_d = 1'b0;
          end else begin
            state_d   = ST_CSUM;
            tx_data_d = csum_d;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (hs_s) begin
          state_d    = ST_IDLE;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          state_d = ST_CSUM;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ctrl_readReg = idx_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;

endmodule
